// File: rtl/l2_response_router_if.sv
// ---------------------------------------------------------------------------
// l2_response_router_if
// Bundles the L2 -> L1 return-path signals of the response router.
//   D channel : l2_d_* from the L2, d_*_o / d_ready_i toward the L1 adapters
//   B channel : l2_b_* from the L2, b_*_o / b_ready_i toward the L1 adapters
//   E channel : e_valid_i / e_ready_o GrantAck handshake from the L1 adapters
//   status    : grant_pending_o, rtr_busy
// Modports:
//   slave  - the router itself (consumes L2 traffic, drives the L1 side)
//   master - the surrounding L2 and L1 adapters (or a testbench)
// ---------------------------------------------------------------------------
interface l2_response_router_if #(
    parameter int NUM_MASTERS = 4,
    parameter int SINK_W      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64
);
    localparam int DEST_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // D channel
    logic                   l2_d_valid;
    logic                   l2_d_ready;
    logic [DEST_W-1:0]      l2_d_dest;
    logic [2:0]             l2_d_opcode;
    logic [1:0]             l2_d_param;
    logic [SINK_W-1:0]      l2_d_sink;
    logic [DATA_W-1:0]      l2_d_data;
    logic [NUM_MASTERS-1:0] d_valid_o;
    logic [NUM_MASTERS-1:0] d_ready_i;
    logic [2:0]             d_opcode_o;
    logic [1:0]             d_param_o;
    logic [SINK_W-1:0]      d_sink_o;
    logic [DATA_W-1:0]      d_data_o;

    // B channel
    logic                   l2_b_valid;
    logic                   l2_b_ready;
    logic [NUM_MASTERS-1:0] l2_b_mask;
    logic [1:0]             l2_b_param;
    logic [ADDR_W-1:0]      l2_b_addr;
    logic [NUM_MASTERS-1:0] b_valid_o;
    logic [NUM_MASTERS-1:0] b_ready_i;
    logic [1:0]             b_param_o;
    logic [ADDR_W-1:0]      b_addr_o;

    // E channel and status
    logic [NUM_MASTERS-1:0] e_valid_i;
    logic [NUM_MASTERS-1:0] e_ready_o;
    logic [NUM_MASTERS-1:0] grant_pending_o;
    logic                   rtr_busy;

    modport slave (
        input  l2_d_valid, l2_d_dest, l2_d_opcode, l2_d_param, l2_d_sink, l2_d_data, d_ready_i,
        output l2_d_ready, d_valid_o, d_opcode_o, d_param_o, d_sink_o, d_data_o,
        input  l2_b_valid, l2_b_mask, l2_b_param, l2_b_addr, b_ready_i,
        output l2_b_ready, b_valid_o, b_param_o, b_addr_o,
        input  e_valid_i,
        output e_ready_o, grant_pending_o, rtr_busy
    );

    modport master (
        output l2_d_valid, l2_d_dest, l2_d_opcode, l2_d_param, l2_d_sink, l2_d_data, d_ready_i,
        input  l2_d_ready, d_valid_o, d_opcode_o, d_param_o, d_sink_o, d_data_o,
        output l2_b_valid, l2_b_mask, l2_b_param, l2_b_addr, b_ready_i,
        input  l2_b_ready, b_valid_o, b_param_o, b_addr_o,
        output e_valid_i,
        input  e_ready_o, grant_pending_o, rtr_busy
    );
endinterface

// File: rtl/l2_response_router.sv
// ---------------------------------------------------------------------------
// l2_response_router
// Return path of the L2 toward the L1 adapters.
//   - D responses are routed through one registered stage to the master named
//     by l2_d_dest (one-hot d_valid_o, shared payload).
//   - Grant/GrantData responses set grant_pending for their master; a GrantAck
//     on e_valid_i clears it. A second Grant to a master still pending stalls.
//   - B probes are multicast to l2_b_mask; each master completes independently.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - l2_response_router_if.slave (D/B/E channels and status)
// ---------------------------------------------------------------------------
module l2_response_router #(
    parameter int NUM_MASTERS = 4,
    parameter int SINK_W      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    l2_response_router_if.slave    bus
);
    localparam int DEST_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [DEST_W:0]      NUM_M  = (DEST_W+1)'(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE_OH = NUM_MASTERS'(1);

    typedef enum logic {B_IDLE, B_SEND} b_state_t;

    // D stage state; destination held one-hot so it drives d_valid_o directly
    logic                   stg_v;
    logic [NUM_MASTERS-1:0] stg_oh;
    logic [2:0]             stg_opcode;
    logic [1:0]             stg_param;
    logic [SINK_W-1:0]      stg_sink;
    logic [DATA_W-1:0]      stg_data;
    logic [NUM_MASTERS-1:0] grant_pending;

    // B path state; pend doubles as the registered b_valid_o
    b_state_t               b_state;
    logic [NUM_MASTERS-1:0] pend;
    logic [1:0]             b_param;
    logic [ADDR_W-1:0]      b_addr;

    logic                   dest_ok;
    logic [NUM_MASTERS-1:0] dest_oh;
    logic                   is_grant;
    logic                   gstall;
    logic                   drain;
    logic                   d_ready;
    logic                   d_acc;
    logic [NUM_MASTERS-1:0] pend_left;

    // Out-of-range destinations are still accepted but decode to no master.
    assign dest_ok  = ({1'b0, bus.l2_d_dest} < NUM_M);
    assign dest_oh  = dest_ok ? (ONE_OH << bus.l2_d_dest) : '0;
    assign is_grant = (bus.l2_d_opcode == 3'd4) || (bus.l2_d_opcode == 3'd5);

    // Uses the registered pending bits, so a GrantAck arriving in the same
    // cycle only releases the stalled Grant on the following cycle.
    assign gstall   = bus.l2_d_valid & is_grant & (|(grant_pending & dest_oh));
    assign drain    = stg_v & (|(stg_oh & bus.d_ready_i));
    assign d_ready  = (~stg_v | drain) & ~gstall;
    assign d_acc    = bus.l2_d_valid & d_ready;

    assign pend_left = pend & ~bus.b_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_v         <= 1'b0;
            stg_oh        <= '0;
            // NOTE: payload registers are reset too, so the shared payload
            // outputs read zero after reset rather than stale data.
            stg_opcode    <= '0;
            stg_param     <= '0;
            stg_sink      <= '0;
            stg_data      <= '0;
            grant_pending <= '0;
        end else begin
            if (d_acc && dest_ok) begin
                stg_v      <= 1'b1;
                stg_oh     <= dest_oh;
                stg_opcode <= bus.l2_d_opcode;
                stg_param  <= bus.l2_d_param;
                stg_sink   <= bus.l2_d_sink;
                stg_data   <= bus.l2_d_data;
            end else if (drain) begin
                stg_v      <= 1'b0;
            end
            // A new Grant can only be accepted for a master whose bit is clear,
            // so set and clear never target the same live bit.
            grant_pending <= (grant_pending & ~bus.e_valid_i)
                           | ((d_acc && is_grant) ? dest_oh : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_state <= B_IDLE;
            pend    <= '0;
            b_param <= '0;
            b_addr  <= '0;
        end else begin
            case (b_state)
                B_IDLE: begin
                    if (bus.l2_b_valid) begin
                        b_param <= bus.l2_b_param;
                        b_addr  <= bus.l2_b_addr;
                        pend    <= bus.l2_b_mask;
                        if (bus.l2_b_mask != '0) b_state <= B_SEND;
                    end
                end
                B_SEND: begin
                    pend <= pend_left;
                    if (pend_left == '0) b_state <= B_IDLE;
                end
                default: begin
                    b_state <= B_IDLE;
                    pend    <= '0;
                end
            endcase
        end
    end

    assign bus.l2_d_ready      = d_ready;
    assign bus.d_valid_o       = stg_v ? stg_oh : '0;
    assign bus.d_opcode_o      = stg_opcode;
    assign bus.d_param_o       = stg_param;
    assign bus.d_sink_o        = stg_sink;
    assign bus.d_data_o        = stg_data;

    assign bus.l2_b_ready      = (b_state == B_IDLE);
    assign bus.b_valid_o       = pend;
    assign bus.b_param_o       = b_param;
    assign bus.b_addr_o        = b_addr;

    assign bus.e_ready_o       = '1;
    assign bus.grant_pending_o = grant_pending;
    assign bus.rtr_busy        = stg_v | (b_state == B_SEND);
endmodule

// File: tb/tb_l2_response_router.sv
// ---------------------------------------------------------------------------
// tb_l2_response_router
// Directed stimulus for l2_response_router with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_l2_response_router;
    localparam int NM = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    l2_response_router_if #(.NUM_MASTERS(NM), .SINK_W(2), .ADDR_W(32), .DATA_W(64)) bus ();

    l2_response_router #(.NUM_MASTERS(NM), .SINK_W(2), .ADDR_W(32), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_beat(input logic [1:0] dest, input logic [2:0] op, input logic [63:0] data);
        bus.l2_d_valid  = 1'b1;
        bus.l2_d_dest   = dest;
        bus.l2_d_opcode = op;
        bus.l2_d_param  = 2'd1;
        bus.l2_d_sink   = 2'd2;
        bus.l2_d_data   = data;
    endtask

    initial begin
        rst = 1'b1;
        bus.l2_d_valid = 1'b0; bus.l2_d_dest = '0; bus.l2_d_opcode = '0;
        bus.l2_d_param = '0;   bus.l2_d_sink = '0; bus.l2_d_data = '0;
        bus.d_ready_i  = 4'b1111;
        bus.l2_b_valid = 1'b0; bus.l2_b_mask = '0; bus.l2_b_param = '0; bus.l2_b_addr = '0;
        bus.b_ready_i  = '0;
        bus.e_valid_i  = '0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst d_valid",    bus.d_valid_o, 0);
        check("rst b_valid",    bus.b_valid_o, 0);
        check("rst pending",    bus.grant_pending_o, 0);
        check("rst e_ready",    bus.e_ready_o, 4'b1111);
        check("rst busy",       bus.rtr_busy, 0);
        check("rst d_data",     bus.d_data_o, 0);
        check("rst b_addr",     bus.b_addr_o, 0);
        check("rst l2_b_ready", bus.l2_b_ready, 1);
        check("rst l2_d_ready", bus.l2_d_ready, 1);

        // 1: single beat to master 2
        d_beat(2'd2, 3'd1, 64'hA5A5);
        #1 check("t1 l2_d_ready", bus.l2_d_ready, 1);
        tick();
        bus.l2_d_valid = 1'b0;
        #1;
        check("t1 d_valid",  bus.d_valid_o, 4'b0100);
        check("t1 d_data",   bus.d_data_o, 64'hA5A5);
        check("t1 d_opcode", bus.d_opcode_o, 1);
        check("t1 busy",     bus.rtr_busy, 1);
        check("t1 l2_d_ready", bus.l2_d_ready, 1);
        tick();
        check("t1 drained", bus.d_valid_o, 0);

        // 2: master 1 back-pressures for 3 cycles, next beat to 3 waits
        bus.d_ready_i = 4'b1101;
        d_beat(2'd1, 3'd0, 64'h11);
        tick();
        d_beat(2'd3, 3'd1, 64'h33);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2 stall ready", bus.l2_d_ready, 0);
            check("t2 hold data",   bus.d_data_o, 64'h11);
            check("t2 hold valid",  bus.d_valid_o, 4'b0010);
            tick();
        end
        bus.d_ready_i = 4'b1111;
        #1 check("t2 release ready", bus.l2_d_ready, 1);
        tick();
        bus.l2_d_valid = 1'b0;
        #1;
        check("t2 second valid", bus.d_valid_o, 4'b1000);
        check("t2 second data",  bus.d_data_o, 64'h33);
        tick();
        check("t2 empty", bus.d_valid_o, 0);

        // 3: two Grants to master 0, second waits for GrantAck
        d_beat(2'd0, 3'd4, 64'h0);
        #1 check("t3 g1 ready", bus.l2_d_ready, 1);
        tick();
        d_beat(2'd0, 3'd4, 64'h0);
        #1;
        check("t3 pending set", bus.grant_pending_o, 4'b0001);
        check("t3 g1 valid",    bus.d_valid_o, 4'b0001);
        check("t3 g1 opcode",   bus.d_opcode_o, 4);
        check("t3 g2 stall",    bus.l2_d_ready, 0);
        tick();
        check("t3 g2 still stall", bus.l2_d_ready, 0);
        check("t3 stage drained",  bus.d_valid_o, 0);
        bus.e_valid_i = 4'b0001;
        #1 check("t3 stall with E", bus.l2_d_ready, 0);
        tick();
        bus.e_valid_i = 4'b0000;
        #1;
        check("t3 pending clear", bus.grant_pending_o, 0);
        check("t3 g2 accept",     bus.l2_d_ready, 1);
        tick();
        bus.l2_d_valid = 1'b0;
        #1;
        check("t3 g2 pending", bus.grant_pending_o, 4'b0001);
        check("t3 g2 valid",   bus.d_valid_o, 4'b0001);
        bus.e_valid_i = 4'b0101;
        tick();
        bus.e_valid_i = 4'b0000;
        #1 check("t3 E on idle bit", bus.grant_pending_o, 0);

        // 4: probe multicast, masters complete out of order
        bus.l2_b_valid = 1'b1;
        bus.l2_b_mask  = 4'b1011;
        bus.l2_b_param = 2'd2;
        bus.l2_b_addr  = 32'hDEAD_BEEF;
        bus.b_ready_i  = 4'b0000;
        #1 check("t4 t0 b_ready", bus.l2_b_ready, 1);
        tick();
        bus.l2_b_valid = 1'b0;
        #1;
        check("t4 t1 b_valid", bus.b_valid_o, 4'b1011);
        check("t4 t1 b_ready", bus.l2_b_ready, 0);
        check("t4 b_addr",     bus.b_addr_o, 32'hDEAD_BEEF);
        check("t4 b_param",    bus.b_param_o, 2);
        check("t4 busy",       bus.rtr_busy, 1);
        bus.b_ready_i = 4'b0001;
        tick();
        check("t4 t2 b_valid", bus.b_valid_o, 4'b1010);
        bus.b_ready_i = 4'b1000;
        tick();
        check("t4 t3 b_valid", bus.b_valid_o, 4'b0010);
        bus.b_ready_i = 4'b0000;
        tick();
        check("t4 t4 b_valid", bus.b_valid_o, 4'b0010);
        check("t4 t4 b_ready", bus.l2_b_ready, 0);
        bus.b_ready_i = 4'b0010;
        tick();
        bus.b_ready_i = 4'b0000;
        #1;
        check("t4 t5 b_valid", bus.b_valid_o, 0);
        check("t4 t5 b_ready", bus.l2_b_ready, 1);

        // 5: empty-mask probe is dropped
        bus.l2_b_valid = 1'b1;
        bus.l2_b_mask  = 4'b0000;
        #1 check("t5 b_ready", bus.l2_b_ready, 1);
        tick();
        bus.l2_b_valid = 1'b0;
        #1;
        check("t5 b_valid", bus.b_valid_o, 0);
        check("t5 idle",    bus.l2_b_ready, 1);
        check("t5 busy",    bus.rtr_busy, 0);

        // 6: reset with D stage full, probe in SEND and a Grant pending
        bus.d_ready_i  = 4'b0000;
        d_beat(2'd2, 3'd5, 64'h77);
        bus.l2_b_valid = 1'b1;
        bus.l2_b_mask  = 4'b1111;
        tick();
        bus.l2_d_valid = 1'b0;
        bus.l2_b_valid = 1'b0;
        #1;
        check("t6 pre pending", bus.grant_pending_o, 4'b0100);
        check("t6 pre d_valid", bus.d_valid_o, 4'b0100);
        check("t6 pre b_valid", bus.b_valid_o, 4'b1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6 d_valid", bus.d_valid_o, 0);
        check("t6 b_valid", bus.b_valid_o, 0);
        check("t6 pending", bus.grant_pending_o, 0);
        check("t6 b_ready", bus.l2_b_ready, 1);
        check("t6 busy",    bus.rtr_busy, 0);
        check("t6 d_data",  bus.d_data_o, 0);
        tick();
        check("t6 quiet d", bus.d_valid_o, 0);
        check("t6 quiet b", bus.b_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
